// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the CPU/DMA memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam int unsigned DEF_AW        = 32;
  localparam int unsigned DEF_DW        = 32;
  localparam int unsigned DEF_MAX_BURST = 4;

  // The requester that is not 'o' (NONE maps to CPU).
  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory port.
// slave: arbiter side; master: requesters and memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rd;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wd;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rd;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    output cpu_gnt, cpu_rvalid, cpu_rd,
    input  dma_req, dma_we, dma_addr, dma_wd,
    output dma_gnt, dma_rvalid, dma_rd,
    output mem_we, mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  cpu_gnt, cpu_rvalid, cpu_rd,
    output dma_req, dma_we, dma_addr, dma_wd,
    input  dma_gnt, dma_rvalid, dma_rd,
    input  mem_we, mem_addr, mem_wd,
    output mem_rd
  );

endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin next-owner and burst-count logic; purely combinational.
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = DEF_MAX_BURST,
  parameter int unsigned BW        = $clog2(MAX_BURST + 1)
) (
  input  logic          cpu_req,
  input  logic          dma_req,
  input  owner_e        owner_q,
  input  owner_e        last_q,
  input  logic [BW-1:0] beat_q,
  output owner_e        owner_d,
  output owner_e        last_d,
  output logic [BW-1:0] beat_d
);

  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);

  // Pick next owner, then derive beat count and last-owner from it.
  always_comb begin
    owner_d = OWN_NONE;
    last_d  = last_q;
    beat_d  = '0;

    if (cpu_req && dma_req) begin
      if (owner_q == OWN_NONE)
        owner_d = other_owner(last_q);
      else if (beat_q < BEAT_MAX)
        owner_d = owner_q;
      else
        owner_d = other_owner(owner_q);
    end else if (cpu_req) begin
      owner_d = OWN_CPU;
    end else if (dma_req) begin
      owner_d = OWN_DMA;
    end

    if (owner_d != OWN_NONE) begin
      if (owner_d == owner_q) begin
        beat_d = (beat_q == BEAT_MAX) ? beat_q : beat_q + BW'(1);
      end else begin
        beat_d = BW'(1);
        last_d = owner_d;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the CPU and the DMA/loader port:
// owner registers, address/data mux, and registered read return.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  owner_e        owner_q, owner_d;
  owner_e        last_q,  last_d;
  logic [BW-1:0] beat_q,  beat_d;

  logic          cpu_gnt, dma_gnt;
  logic          mem_we_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wd_c;

  logic          cpu_rvalid_q, dma_rvalid_q;
  logic [DW-1:0] cpu_rd_q, dma_rd_q;

  mem_arb_rr #(
    .MAX_BURST (MAX_BURST),
    .BW        (BW)
  ) u_rr (
    .cpu_req (bus.cpu_req),
    .dma_req (bus.dma_req),
    .owner_q (owner_q),
    .last_q  (last_q),
    .beat_q  (beat_q),
    .owner_d (owner_d),
    .last_d  (last_d),
    .beat_d  (beat_d)
  );

  // Arbitration state; last_q resets to DMA so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
      last_q  <= OWN_DMA;
      beat_q  <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Grants and memory command decode straight from the registered owner.
  always_comb begin
    cpu_gnt    = (owner_q == OWN_CPU) && bus.cpu_req;
    dma_gnt    = (owner_q == OWN_DMA) && bus.dma_req;
    mem_we_c   = 1'b0;
    mem_addr_c = '0;
    mem_wd_c   = '0;
    case (owner_q)
      OWN_CPU: begin
        mem_addr_c = bus.cpu_addr;
        mem_wd_c   = bus.cpu_wd;
        mem_we_c   = cpu_gnt && bus.cpu_we;
      end
      OWN_DMA: begin
        mem_addr_c = bus.dma_addr;
        mem_wd_c   = bus.dma_wd;
        mem_we_c   = dma_gnt && bus.dma_we;
      end
      default: ;
    endcase
  end

  // Capture read data on a granted read and pulse rvalid for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rd_q     <= '0;
      dma_rd_q     <= '0;
    end else begin
      cpu_rvalid_q <= cpu_gnt && !bus.cpu_we;
      dma_rvalid_q <= dma_gnt && !bus.dma_we;
      if (cpu_gnt && !bus.cpu_we) cpu_rd_q <= bus.mem_rd;
      if (dma_gnt && !bus.dma_we) dma_rd_q <= bus.mem_rd;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.cpu_rd     = cpu_rd_q;
  assign bus.dma_rd     = dma_rd_q;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wd     = mem_wd_c;

`ifndef SYNTHESIS
  // A requester must keep req high until it has been granted.
  a_cpu_req_held: assert property (@(posedge clk) disable iff (!reset)
    (bus.cpu_req && !cpu_gnt) |=> bus.cpu_req);
  a_dma_req_held: assert property (@(posedge clk) disable iff (!reset)
    (bus.dma_req && !dma_gnt) |=> bus.dma_req);
`endif

endmodule
